// File: rtl/seg7_scan_bcd_n.sv
// Time-multiplexed 7-segment driver: BCD/hex digits, decimal points, leading-zero
// blanking, per-digit blink, and a frame-aligned shadow register for display updates.
module seg7_scan_bcd_n #(
   parameter int DIGITS         = 4,
   parameter int CLK_HZ         = 50000000,
   parameter int SCAN_HZ        = 1000,
   parameter int BLINK_HZ       = 2,
   parameter bit HEX_EN         = 1'b0,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [4*DIGITS-1:0]   upd_bcd,
   input  logic [DIGITS-1:0]     upd_dp,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic                  blank_lz_en,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [DIGITS-1:0]     sel,
   output logic [7:0]            seg
);

   localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

   localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [SW-1:0]          scan_cnt;
   logic [BW-1:0]          blink_cnt;
   logic                   blink_ph;
   logic [IW-1:0]          idx;
   logic                   scan_tick;
   logic                   frame_end;

   logic [4*DIGITS-1:0]    disp_bcd;
   logic [DIGITS-1:0]      disp_dp;
   logic [4*DIGITS-1:0]    sh_bcd;
   logic [DIGITS-1:0]      sh_dp;
   logic                   sh_full;
   logic                   accept;

   logic [DIGITS-1:0]      lz_blank;
   logic                   lz_chain;
   logic [DIGITS-1:0]      onehot;
   logic [3:0]             cur_code;
   logic                   cur_dp;
   logic                   cur_lz;
   logic                   cur_bm;
   logic                   cur_blank;
   logic [7:0]             cur_seg;

   function automatic logic [6:0] seg_pattern(input logic [3:0] code);
      logic [6:0] p;
      case (code)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = HEX_EN ? 7'h77 : 7'h00;
         4'hB:    p = HEX_EN ? 7'h7C : 7'h00;
         4'hC:    p = HEX_EN ? 7'h39 : 7'h00;
         4'hD:    p = HEX_EN ? 7'h5E : 7'h00;
         4'hE:    p = HEX_EN ? 7'h79 : 7'h00;
         default: p = HEX_EN ? 7'h71 : 7'h00;
      endcase
      return p;
   endfunction

   assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));
   assign frame_end = scan_tick && (idx == IW'(DIGITS - 1));
   assign upd_ready = ~sh_full;
   assign accept    = upd_valid && ~sh_full;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scan_cnt  <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         if (scan_tick) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end
         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end
   end

   // Accept only while the shadow is empty, so accept and commit never collide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh_bcd   <= '0;
         sh_dp    <= '0;
         sh_full  <= 1'b0;
         disp_bcd <= '0;
         disp_dp  <= '0;
      end else if (accept) begin
         sh_bcd  <= upd_bcd;
         sh_dp   <= upd_dp;
         sh_full <= 1'b1;
      end else if (frame_end && sh_full) begin
         disp_bcd <= sh_bcd;
         disp_dp  <= sh_dp;
         sh_full  <= 1'b0;
      end
   end

   // Walk from the most significant digit down; any non-zero code or lit dp ends the chain.
   always_comb begin
      lz_chain = 1'b1;
      lz_blank = '0;
      for (int j = DIGITS - 1; j >= 0; j--) begin
         lz_chain    = lz_chain && (disp_bcd[4*j +: 4] == 4'd0) && !disp_dp[j];
         lz_blank[j] = (j != 0) && lz_chain;
      end
   end

   always_comb begin
      cur_code = 4'd0;
      cur_dp   = 1'b0;
      cur_lz   = 1'b0;
      cur_bm   = 1'b0;
      onehot   = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_code  = disp_bcd[4*k +: 4];
            cur_dp    = disp_dp[k];
            cur_lz    = lz_blank[k];
            cur_bm    = blink_mask[k];
            onehot[k] = 1'b1;
         end
      end
      cur_blank = (blank_lz_en && cur_lz) || (cur_bm && blink_ph);
      cur_seg   = {cur_dp, seg_pattern(cur_code)};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel <= SEL_OFF;
         seg <= SEG_OFF;
      end else if (cur_blank) begin
         sel <= SEL_OFF;
         seg <= SEG_OFF;
      end else begin
         sel <= SEL_ACTIVE_LOW ? ~onehot  : onehot;
         seg <= SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
      end
   end

endmodule

// File: tb/tb_seg7_scan_bcd_n.sv
// Bench for seg7_scan_bcd_n: a queue of pending updates predicts every scanned
// output frame for a HEX_EN=0 and a HEX_EN=1 instance driven in parallel.
module tb_seg7_scan_bcd_n;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] upd_bcd = '0;
   logic [3:0]  upd_dp = '0;
   logic        upd_valid = 1'b0;
   logic        blank_lz_en = 1'b0;
   logic [3:0]  blink_mask = '0;
   logic        ready0, ready1;
   logic [3:0]  sel0, sel1;
   logic [7:0]  seg0, seg1;

   seg7_scan_bcd_n #(.DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(250), .BLINK_HZ(25),
      .HEX_EN(1'b0), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut0 (
      .clk(clk), .rstn(rstn), .upd_bcd(upd_bcd), .upd_dp(upd_dp), .upd_valid(upd_valid),
      .upd_ready(ready0), .blank_lz_en(blank_lz_en), .blink_mask(blink_mask),
      .sel(sel0), .seg(seg0));

   seg7_scan_bcd_n #(.DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(250), .BLINK_HZ(25),
      .HEX_EN(1'b1), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
      .clk(clk), .rstn(rstn), .upd_bcd(upd_bcd), .upd_dp(upd_dp), .upd_valid(upd_valid),
      .upd_ready(ready1), .blank_lz_en(blank_lz_en), .blink_mask(blink_mask),
      .sel(sel1), .seg(seg1));

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  dp;
      int          commit;
   } upd_t;

   upd_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [15:0] cur_bcd = '0;
   logic [3:0]  cur_dp = '0;
   logic        lz_s;
   logic [3:0]  bm_s;
   int          m_idx;
   bit          m_ph;
   logic [11:0] e0, e1;

   function automatic logic [6:0] pat(input logic [3:0] c, input bit hex);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      if (c > 4'd9 && !hex) return 7'h00;
      return t[c];
   endfunction

   function automatic logic [11:0] expect_out(input logic [15:0] b, input logic [3:0] d,
         input int idx, input bit ph, input logic lz, input logic [3:0] bm, input bit hex);
      bit         blank;
      bit         chain;
      logic [3:0] s;
      blank = bm[idx] && ph;
      if (lz && idx > 0) begin
         chain = 1'b1;
         for (int j = idx; j < 4; j++)
            if (b[4*j +: 4] != 4'd0 || d[j]) chain = 1'b0;
         if (chain) blank = 1'b1;
      end
      if (blank) return {4'hF, 8'hFF};
      s = 4'hF;
      s[idx] = 1'b0;
      return {s, ~{d[idx], pat(b[4*idx +: 4], hex)}};
   endfunction

   function automatic bit model_ready();
      return (q.size() == 0) || (q[$].commit <= cyc);
   endfunction

   // Output after posedge cyc reflects idx/phase/display as they stood just before that edge.
   initial forever begin
      @(posedge clk);
      if (rstn) begin
         cyc++;
         lz_s = blank_lz_en;
         bm_s = blink_mask;
         if (q.size() > 0 && cyc - 1 >= q[0].commit) begin
            cur_bcd = q[0].bcd;
            cur_dp  = q[0].dp;
            void'(q.pop_front());
         end
         #1;
         if (mon_en && rstn) begin
            m_idx = ((cyc - 1) / 4) % 4;
            m_ph  = (((cyc - 1) / 20) % 2) == 1;
            e0 = expect_out(cur_bcd, cur_dp, m_idx, m_ph, lz_s, bm_s, 1'b0);
            e1 = expect_out(cur_bcd, cur_dp, m_idx, m_ph, lz_s, bm_s, 1'b1);
            checks++;
            if ({sel0, seg0} !== e0) begin
               failures++;
               $display("FAIL scan_hex0 cyc=%0d sel/seg=%h/%h required %h/%h",
                        cyc, sel0, seg0, e0[11:8], e0[7:0]);
            end
            checks++;
            if ({sel1, seg1} !== e1) begin
               failures++;
               $display("FAIL scan_hex1 cyc=%0d sel/seg=%h/%h required %h/%h",
                        cyc, sel1, seg1, e1[11:8], e1[7:0]);
            end
         end
      end
   end

   task automatic offer(input logic [15:0] b, input logic [3:0] d);
      upd_t u;
      @(negedge clk);
      upd_bcd = b;
      upd_dp = d;
      upd_valid = 1'b1;
      for (int k = 0; k < 64 && !model_ready(); k++) @(negedge clk);
      u.bcd = b;
      u.dp = d;
      u.commit = ((cyc + 1) / 16 + 1) * 16;
      q.push_back(u);
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   task automatic wait_digit(input int want);
      for (int k = 0; k < 20 && (((cyc - 1) / 4) % 4) != want; k++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rstn = 1'b0;
      q.delete();
      cyc = 0;
      cur_bcd = '0;
      cur_dp = '0;
      #1;
      checks++;
      if ({ready0, sel0, seg0} !== {1'b1, 4'hF, 8'hFF}) begin
         failures++;
         $display("FAIL async_reset ready/sel/seg=%b/%h/%h required 1/f/ff", ready0, sel0, seg0);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({ready0, sel0, seg0} !== {1'b1, 4'hF, 8'hFF}) begin
         failures++;
         $display("FAIL reset_dut0 ready/sel/seg=%b/%h/%h required 1/f/ff", ready0, sel0, seg0);
      end
      checks++;
      if ({ready1, sel1, seg1} !== {1'b1, 4'hF, 8'hFF}) begin
         failures++;
         $display("FAIL reset_dut1 ready/sel/seg=%b/%h/%h required 1/f/ff", ready1, sel1, seg1);
      end
      rstn = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic test_digits();
      offer(16'h1234, 4'b0000);
      repeat (40) @(negedge clk);
      wait_digit(1);
      checks++;
      if ({sel0, seg0} !== {4'b1101, 8'hB0}) begin
         failures++;
         $display("FAIL digits_d1 sel/seg=%b/%h required 1101/b0", sel0, seg0);
      end
      wait_digit(3);
      checks++;
      if ({sel0, seg0} !== {4'b0111, 8'hF9}) begin
         failures++;
         $display("FAIL digits_d3 sel/seg=%b/%h required 0111/f9", sel0, seg0);
      end
   endtask

   task automatic test_lzb();
      blank_lz_en = 1'b1;
      offer(16'h0050, 4'b0000);
      repeat (40) @(negedge clk);
      wait_digit(3);
      checks++;
      if ({sel0, seg0} !== {4'hF, 8'hFF}) begin
         failures++;
         $display("FAIL lzb_d3 sel/seg=%b/%h required 1111/ff", sel0, seg0);
      end
      wait_digit(1);
      checks++;
      if ({sel0, seg0} !== {4'b1101, 8'h92}) begin
         failures++;
         $display("FAIL lzb_d1 sel/seg=%b/%h required 1101/92", sel0, seg0);
      end
      offer(16'h0050, 4'b0100);
      repeat (40) @(negedge clk);
      wait_digit(2);
      checks++;
      if ({sel0, seg0} !== {4'b1011, 8'h40}) begin
         failures++;
         $display("FAIL lzb_dp_d2 sel/seg=%b/%h required 1011/40", sel0, seg0);
      end
      blank_lz_en = 1'b0;
   endtask

   task automatic test_handshake();
      upd_t u;
      for (int k = 0; k < 20 && (cyc % 16) != 4; k++) @(negedge clk);
      upd_bcd = 16'h0007;
      upd_dp = 4'b0000;
      upd_valid = 1'b1;
      u.bcd = 16'h0007; u.dp = 4'b0000; u.commit = ((cyc + 1) / 16 + 1) * 16;
      q.push_back(u);
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b0) begin
         failures++;
         $display("FAIL hs_ready_drop ready=%b required 0", ready0);
      end
      upd_bcd = 16'h0008;
      for (int k = 0; k < 40 && !model_ready(); k++) begin
         checks++;
         if (ready0 !== 1'b0) begin
            failures++;
            $display("FAIL hs_b_blocked cyc=%0d ready=%b required 0", cyc, ready0);
         end
         @(negedge clk);
      end
      checks++;
      if (ready0 !== 1'b1) begin
         failures++;
         $display("FAIL hs_ready_return ready=%b required 1", ready0);
      end
      u.bcd = 16'h0008; u.commit = ((cyc + 1) / 16 + 1) * 16;
      q.push_back(u);
      @(negedge clk);
      upd_valid = 1'b0;
      checks++;
      if (ready0 !== 1'b0) begin
         failures++;
         $display("FAIL hs_b_taken ready=%b required 0", ready0);
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic test_coincide();
      for (int k = 0; k < 20 && (cyc % 16) != 14; k++) @(negedge clk);
      offer(16'h0006, 4'b0000);
      @(negedge clk);
      checks++;
      if (seg0 !== 8'h80) begin
         failures++;
         $display("FAIL coincide_old seg=%h required 80", seg0);
      end
      repeat (16) @(negedge clk);
      checks++;
      if (seg0 !== 8'h82) begin
         failures++;
         $display("FAIL coincide_new seg=%h required 82", seg0);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_pending();
      offer(16'h4321, 4'b1111);
      checks++;
      if (ready0 !== 1'b0) begin
         failures++;
         $display("FAIL pend_full ready=%b required 0", ready0);
      end
      do_reset();
      repeat (20) @(negedge clk);
      wait_digit(0);
      checks++;
      if ({ready0, sel0, seg0} !== {1'b1, 4'b1110, 8'hC0}) begin
         failures++;
         $display("FAIL pend_discard ready/sel/seg=%b/%b/%h required 1/1110/c0", ready0, sel0, seg0);
      end
   endtask

   task automatic test_blink();
      blink_mask = 4'b0001;
      do_reset();
      for (int k = 0; k < 40 && cyc != 17; k++) @(negedge clk);
      checks++;
      if ({sel0, seg0} !== {4'b1110, 8'hC0}) begin
         failures++;
         $display("FAIL blink_on sel/seg=%b/%h required 1110/c0", sel0, seg0);
      end
      for (int k = 0; k < 40 && cyc != 33; k++) @(negedge clk);
      checks++;
      if ({sel0, seg0} !== {4'hF, 8'hFF}) begin
         failures++;
         $display("FAIL blink_off sel/seg=%b/%h required 1111/ff", sel0, seg0);
      end
      repeat (30) @(negedge clk);
      blink_mask = 4'b0000;
   endtask

   task automatic test_hex();
      offer(16'h000B, 4'b0000);
      repeat (40) @(negedge clk);
      wait_digit(0);
      checks++;
      if ({sel0, seg0} !== {4'b1110, 8'hFF}) begin
         failures++;
         $display("FAIL hex_off sel/seg=%b/%h required 1110/ff", sel0, seg0);
      end
      checks++;
      if ({sel1, seg1} !== {4'b1110, 8'h83}) begin
         failures++;
         $display("FAIL hex_on sel/seg=%b/%h required 1110/83", sel1, seg1);
      end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_digits();
      test_lzb();
      test_handshake();
      test_coincide();
      test_reset_pending();
      test_blink();
      test_hex();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
